expr_eval: RTL and testbench

Parametrised ASCII arithmetic-expression recognizer and evaluator. Consumes one character per accepted cycle and tracks whether the stream so far forms a well-formed expression of the form number (op number)*. It accepts multi-digit decimal numbers and the operators `+`, `*` and optionally `-`, with `*` binding tighter than `+`/`-`. It keeps a running result modulo 2^W and terminates an expression on `=`. It sits behind the character source in the input-parsing path and successively replaces the single-digit `+`/`*` string checker.

---
 rtl/expr_eval_if.sv | 11 +
 rtl/expr_eval.sv | 100 ++++++++++
 tb/tb_expr_eval.sv | 132 +++++++++++++
 3 files changed

// File: rtl/expr_eval_if.sv
// expr_eval_if: character stream in, recognizer status and running result out.
interface expr_eval_if #(parameter int W = 16);
  logic in_valid;
  logic [7:0] in;
  logic valid;
  logic done;
  logic err;
  logic [W-1:0] result;
  modport master(output in_valid, in, input valid, done, err, result);
  modport slave(input in_valid, in, output valid, done, err, result);
endinterface

// File: rtl/expr_eval.sv
// expr_eval: streaming recognizer/evaluator for number (op number)* with * above +/-, ended by =.
module expr_eval #(
  parameter int W = 16,
  parameter int MAX_DIGITS = 5,
  parameter int ALLOW_SUB = 1
) (
  input logic clk,
  input logic clr,
  expr_eval_if.slave bus
);
  localparam int ND = $clog2(MAX_DIGITS + 1);
  localparam logic [1:0] START = 2'd0, NUM = 2'd1, OP = 2'd2, ERR = 2'd3;
  logic [1:0] state, state_n;
  logic [W-1:0] sum, sum_n, prod, prod_n, num, num_n, res, res_n, d, grow, term;
  logic [ND-1:0] ndig, ndig_n;
  logic neg, neg_n, done, done_n, wipe;
  logic is_dig, is_add, is_sub, is_mul, is_eq;
  always_comb begin
    is_dig = bus.in >= 8'h30 && bus.in <= 8'h39;
    is_add = bus.in == 8'h2b;
    is_sub = ALLOW_SUB != 0 && bus.in == 8'h2d;
    is_mul = bus.in == 8'h2a;
    is_eq = bus.in == 8'h3d;
    d = W'(bus.in[3:0]);
    grow = num * W'(10) + d;
    term = prod * num;
    state_n = state;
    sum_n = sum;
    prod_n = prod;
    num_n = num;
    neg_n = neg;
    ndig_n = ndig;
    done_n = 1'b0;
    wipe = 1'b0;
    if (bus.in_valid)
      case (state)
        START, OP: begin
          state_n = is_dig ? NUM : ERR;
          num_n = d;
          ndig_n = ND'(1);
        end
        NUM:
          if (is_dig) begin
            state_n = ndig < ND'(MAX_DIGITS) ? NUM : ERR;
            num_n = grow;
            ndig_n = ndig + ND'(1);
          end else if (is_add || is_sub) begin
            sum_n = neg ? sum - term : sum + term;
            neg_n = is_sub;
            prod_n = W'(1);
            state_n = OP;
          end else if (is_mul) begin
            prod_n = term;
            state_n = OP;
          end else if (is_eq) begin
            state_n = START;
            done_n = 1'b1;
            wipe = 1'b1;
          end else state_n = ERR;
        default:
          if (is_eq) begin
            state_n = START;
            wipe = 1'b1;
          end
      endcase
    if (wipe) begin
      sum_n = '0;
      prod_n = W'(1);
      neg_n = 1'b0;
      num_n = '0;
      ndig_n = '0;
    end
    // result tracks the partial value only while the stream ends in a digit
    res_n = state_n == NUM ? (neg ? sum - prod * num_n : sum + prod * num_n) : res;
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= START;
      sum <= '0;
      prod <= W'(1);
      num <= '0;
      neg <= 1'b0;
      ndig <= '0;
      res <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      sum <= sum_n;
      prod <= prod_n;
      num <= num_n;
      neg <= neg_n;
      ndig <= ndig_n;
      res <= res_n;
      done <= done_n;
    end
  assign bus.valid = state == NUM;
  assign bus.err = state == ERR;
  assign bus.done = done;
  assign bus.result = res;
endmodule

// File: tb/tb_expr_eval.sv
// tb_expr_eval: directed character streams into three configurations, scoreboard-checked.
module tb_expr_eval;
  typedef struct packed {logic v; logic d; logic e; logic [15:0] r;} exp_t;
  logic clk = 1'b0;
  logic clr = 1'b1;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  expr_eval_if #(.W(16)) i0();
  expr_eval_if #(.W(8)) i1();
  expr_eval_if #(.W(16)) i2();
  expr_eval #(.W(16), .MAX_DIGITS(5), .ALLOW_SUB(1)) u0(.clk(clk), .clr(clr), .bus(i0.slave));
  expr_eval #(.W(8), .MAX_DIGITS(5), .ALLOW_SUB(1)) u1(.clk(clk), .clr(clr), .bus(i1.slave));
  expr_eval #(.W(16), .MAX_DIGITS(5), .ALLOW_SUB(0)) u2(.clk(clk), .clr(clr), .bus(i2.slave));
  function automatic exp_t obs(int u);
    if (u == 0) return {i0.valid, i0.done, i0.err, i0.result};
    if (u == 1) return {i1.valid, i1.done, i1.err, 8'h00, i1.result};
    return {i2.valid, i2.done, i2.err, i2.result};
  endfunction
  task automatic check(int u, string tag);
    exp_t e, o;
    e = q.pop_front();
    o = obs(u);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got v=%b d=%b e=%b r=%0d, want v=%b d=%b e=%b r=%0d",
             tag, o.v, o.d, o.e, o.r, e.v, e.d, e.e, e.r);
    end
  endtask
  task automatic step(int u, logic iv, logic [7:0] ch, logic v, logic d, logic e, logic [15:0] r);
    i0.in_valid = 1'b0;
    i1.in_valid = 1'b0;
    i2.in_valid = 1'b0;
    if (u == 0) begin i0.in_valid = iv; i0.in = ch; end
    if (u == 1) begin i1.in_valid = iv; i1.in = ch; end
    if (u == 2) begin i2.in_valid = iv; i2.in = ch; end
    q.push_back({v, d, e, r});
    @(posedge clk);
    #1;
    check(u, $sformatf("u%0d %s'%c'", u, iv ? "chr" : "idle", ch));
  endtask
  initial begin
    i0.in_valid = 1'b0; i0.in = 8'h00;
    i1.in_valid = 1'b0; i1.in = 8'h00;
    i2.in_valid = 1'b0; i2.in = 8'h00;
    #12;
    for (int u = 0; u < 3; u++) begin
      q.push_back(exp_t'(0));
      check(u, $sformatf("reset u%0d", u));
    end
    clr = 1'b0;
    step(0, 1, "1", 1, 0, 0, 1);
    step(0, 1, "2", 1, 0, 0, 12);
    step(0, 1, "+", 0, 0, 0, 12);
    step(0, 1, "3", 1, 0, 0, 15);
    step(0, 1, "*", 0, 0, 0, 15);
    step(0, 1, "4", 1, 0, 0, 24);
    step(0, 1, "=", 0, 1, 0, 24);
    step(0, 0, "=", 0, 0, 0, 24);
    step(0, 1, ":", 0, 0, 1, 24);
    step(0, 1, "5", 0, 0, 1, 24);
    step(0, 1, "=", 0, 0, 0, 24);
    step(0, 1, "9", 1, 0, 0, 9);
    step(0, 1, "=", 0, 1, 0, 9);
    step(0, 1, "+", 0, 0, 1, 9);
    step(0, 1, "3", 0, 0, 1, 9);
    step(0, 1, "=", 0, 0, 0, 9);
    step(0, 1, "1", 1, 0, 0, 1);
    step(0, 1, "2", 1, 0, 0, 12);
    step(0, 1, "3", 1, 0, 0, 123);
    step(0, 1, "4", 1, 0, 0, 1234);
    step(0, 1, "5", 1, 0, 0, 12345);
    step(0, 1, "6", 0, 0, 1, 12345);
    step(0, 1, "=", 0, 0, 0, 12345);
    step(0, 1, "2", 1, 0, 0, 2);
    step(0, 1, "*", 0, 0, 0, 2);
    step(0, 1, "3", 1, 0, 0, 6);
    step(0, 1, "+", 0, 0, 0, 6);
    step(0, 1, "4", 1, 0, 0, 10);
    step(0, 1, "*", 0, 0, 0, 10);
    step(0, 1, "5", 1, 0, 0, 26);
    step(0, 1, "-", 0, 0, 0, 26);
    step(0, 1, "1", 1, 0, 0, 25);
    step(0, 1, "=", 0, 1, 0, 25);
    step(0, 1, "7", 1, 0, 0, 7);
    step(0, 1, "=", 0, 1, 0, 7);
    step(0, 1, "8", 1, 0, 0, 8);
    step(0, 1, "=", 0, 1, 0, 8);
    step(0, 1, "1", 1, 0, 0, 1);
    step(0, 0, "2", 1, 0, 0, 1);
    step(0, 0, "2", 1, 0, 0, 1);
    step(0, 0, "2", 1, 0, 0, 1);
    step(0, 1, "2", 1, 0, 0, 12);
    step(0, 1, "3", 1, 0, 0, 123);
    step(0, 1, "=", 0, 1, 0, 123);
    step(0, 1, "7", 1, 0, 0, 7);
    step(0, 1, "*", 0, 0, 0, 7);
    step(0, 1, "8", 1, 0, 0, 56);
    #1 clr = 1'b1;
    #1;
    q.push_back(exp_t'(0));
    check(0, "async clr");
    #1 clr = 1'b0;
    step(0, 1, "4", 1, 0, 0, 4);
    step(1, 1, "2", 1, 0, 0, 2);
    step(1, 1, "0", 1, 0, 0, 20);
    step(1, 1, "0", 1, 0, 0, 200);
    step(1, 1, "+", 0, 0, 0, 200);
    step(1, 1, "1", 1, 0, 0, 201);
    step(1, 1, "0", 1, 0, 0, 210);
    step(1, 1, "0", 1, 0, 0, 44);
    step(1, 1, "=", 0, 1, 0, 44);
    step(1, 1, "1", 1, 0, 0, 1);
    step(1, 1, "6", 1, 0, 0, 16);
    step(1, 1, "*", 0, 0, 0, 16);
    step(1, 1, "1", 1, 0, 0, 16);
    step(1, 1, "6", 1, 0, 0, 0);
    step(1, 1, "=", 0, 1, 0, 0);
    step(1, 1, "5", 1, 0, 0, 5);
    step(1, 1, "-", 0, 0, 0, 5);
    step(1, 1, "7", 1, 0, 0, 16'h00fe);
    step(1, 1, "=", 0, 1, 0, 16'h00fe);
    step(2, 1, "5", 1, 0, 0, 5);
    step(2, 1, "-", 0, 0, 1, 5);
    step(2, 1, "=", 0, 0, 0, 5);
    step(2, 1, "3", 1, 0, 0, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
